locker_code_checker: RTL and testbench
======================================

// Module: locker_code_checker
// PURPOSE
//  Sequential, parametrised code checker for the digital locker.
//  - Takes keypad digits one per clock and compares them digit by digit against a stored code.
//  - Counts failed attempts and enforces a timed lockout after MAX_FAIL consecutive failures.
//  - Allows the code to be reprogrammed while unlocked.
//  - Sits between the keypad decoder and the lock actuator/status LEDs.
// PARAMETERS
//  DIGIT_W      4        bits per digit
//  CODE_LEN     4        digits per code (>=1)
//  MAX_FAIL     3        consecutive failures that trigger lockout (>=1)
//  LOCKOUT_CYC  16       lockout duration in clk cycles (>=1)
//  RESET_CODE   16'h1234 stored code after reset; digit 0 in the MS DIGIT_W bits; width DIGIT_W*CODE_LEN
//  RELOCK_CYC   64       idle cycles before auto-relock (used only with LOCKER_AUTO_RELOCK_EN)
// PORTS
//  clk          in   1                   single clock, rising edge
//  rst          in   1                   synchronous, active-high reset
//  digit_valid  in   1                   digit strobe, one digit per cycle when high
//  digit        in   DIGIT_W             digit value, any value accepted (no BCD check)
//  clear        in   1                   abort current entry
//  lock_cmd     in   1                   relock request
//  prog_req     in   1                   start reprogramming (honoured only when UNLOCKED)
//  unlocked     out  1                   level, high in UNLOCKED/PROGRAM
//  locked_out   out  1                   level, high in LOCKOUT
//  bad_code     out  1                   1-cycle pulse on a wrong code
//  code_saved   out  1                   1-cycle pulse on new-code commit
//  fail_cnt     out  $clog2(MAX_FAIL+1)  consecutive-failure count
//  digit_idx    out  $clog2(CODE_LEN+1)  digits entered so far
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset: state=LOCKED, stored=RESET_CODE, all outputs 0, mismatch flag cleared.
//  - Priority: rst > clear > lock_cmd > prog_req > digit_valid.
//  - LOCKED:
//    - On digit_valid: compare digit with stored[digit_idx]; OR the result into a sticky mismatch flag; digit_idx++.
//    - On the CODE_LEN-th digit (same edge) the entry is resolved:
//      - All match: next state UNLOCKED; unlocked=1 on the cycle after the last digit; fail_cnt=0.
//      - Any mismatch, fail_cnt+1<MAX_FAIL: stay LOCKED; fail_cnt++; bad_code pulses on the next cycle.
//      - Any mismatch, fail_cnt+1==MAX_FAIL: next state LOCKOUT; bad_code pulses; timer=LOCKOUT_CYC-1.
//    - Every resolution clears digit_idx and the mismatch flag.
//    - clear: digit_idx=0, mismatch flag cleared, fail_cnt unchanged, same-cycle digit discarded.
//  - LOCKOUT:
//    - digit_valid, clear, lock_cmd and prog_req are ignored.
//    - Timer decrements every cycle; when timer==0, next state LOCKED and fail_cnt=0.
//    - locked_out is high for exactly LOCKOUT_CYC cycles.
//  - UNLOCKED:
//    - digit_valid ignored; lock_cmd -> LOCKED; prog_req -> PROGRAM.
//    - lock_cmd and prog_req together: lock_cmd wins.
//  - PROGRAM:
//    - Digits are written into a shadow register at digit_idx.
//    - On the CODE_LEN-th digit: shadow is copied to stored; code_saved pulses; return to UNLOCKED.
//    - clear or lock_cmd aborts: stored code unchanged; clear -> UNLOCKED, lock_cmd -> LOCKED.
//  - digit_idx is modulo CODE_LEN and never exceeds CODE_LEN-1 while an entry is open.
//  - Reset mid-entry or mid-lockout returns to the reset state immediately.
//  - Reset mid-PROGRAM discards the shadow; stored reverts to RESET_CODE.
// CONFIGURATION
//  - Macro LOCKER_AUTO_RELOCK_EN.
//  - Defined:
//    - An idle counter runs in UNLOCKED; any digit_valid or prog_req reloads it.
//    - After RELOCK_CYC idle cycles the state returns to LOCKED; unlocked drops on the next cycle.
//    - The counter is frozen in PROGRAM.
//  - Undefined: UNLOCKED persists until lock_cmd or rst; no counter logic is instantiated.
// STRUCTURE
//  - Package locker_pkg:
//    - Enum locker_state_t {LOCKED, UNLOCKED, PROGRAM, LOCKOUT}.
//    - Default DIGIT_W/CODE_LEN constants.
//    - Function digit_at(code, idx) returning the DIGIT_W slice.
//  - Sub-module locker_down_timer:
//    - Loadable down-counter with a zero flag.
//    - Instanced once for lockout; a second instance for relock under LOCKER_AUTO_RELOCK_EN.
//  - FSM, stored/shadow registers and the mismatch flag live in the top level.
// TESTING
//  - Correct code: after rst, digits 1,2,3,4 on consecutive cycles -> unlocked=1 the cycle after 4; fail_cnt=0.
//  - Wrong code: digits 1,2,3,5 -> bad_code 1-cycle pulse; fail_cnt=1; unlocked=0; digit_idx=0.
//  - Lockout: 3 wrong codes -> locked_out=1 for exactly 16 cycles; digits in that window have no effect;
//    then 1,2,3,4 -> unlocked.
//  - Reprogram: unlock; prog_req; digits 9,8,7,6 -> code_saved pulse; lock_cmd; 1,2,3,4 -> bad_code; 9,8,7,6 -> unlocked.
//  - Abort and priority: 1,2 then clear with digit_valid same cycle -> digit_idx=0, fail_cnt unchanged;
//    lock_cmd+prog_req together in UNLOCKED -> LOCKED.
//  - Auto-relock (macro defined): unlock, idle 64 cycles -> unlocked=0 on cycle 65; rst mid-lockout -> locked_out=0 next cycle.

Source files
------------

// File: rtl/locker_pkg.sv
// rtl/locker_pkg.sv - shared types, default sizes and digit helper for the locker code checker
//
// Purpose: FSM state type, default code geometry and a digit slicer shared by
//          the locker code checker and its sub-modules.
// Ports:   none (package).

package locker_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    PROGRAM  = 2'd2,
    LOCKOUT  = 2'd3
  } locker_state_t;

  localparam int unsigned DEF_DIGIT_W  = 4;
  localparam int unsigned DEF_CODE_LEN = 4;

  // Widest code the helper can slice; codes are zero-extended into this.
  localparam int unsigned MAX_CODE_W = 64;

  // Digit idx of a code_len-digit code, digit 0 in the most significant slot.
  // The result is right-aligned; callers cast it down to their digit width.
  function automatic logic [MAX_CODE_W-1:0] digit_at(
    input logic [MAX_CODE_W-1:0] code,
    input int unsigned           idx,
    input int unsigned           digit_w,
    input int unsigned           code_len
  );
    logic [MAX_CODE_W-1:0] mask;
    mask = (MAX_CODE_W'(1) << digit_w) - MAX_CODE_W'(1);
    return (code >> ((code_len - 1 - idx) * digit_w)) & mask;
  endfunction

endpackage

// File: rtl/locker_down_timer.sv
// rtl/locker_down_timer.sv - loadable down-counter with a zero flag
//
// Purpose: counts down from a loaded value while enabled and holds at zero.
// Ports:
//   clk       in  1  clock, rising edge
//   rst       in  1  synchronous active-high reset (count -> 0)
//   load      in  1  load load_val (wins over en)
//   load_val  in  W  value to load
//   en        in  1  decrement enable
//   zero      out 1  count is zero

module locker_down_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/locker_code_checker.sv
// rtl/locker_code_checker.sv - sequential keypad code checker with lockout and reprogramming
//
// Purpose: compares keypad digits against a stored code one per clock, counts
//          consecutive failures, enforces a timed lockout and allows the code to
//          be reprogrammed while unlocked. Optional auto-relock is built when
//          LOCKER_AUTO_RELOCK_EN is defined.
// Ports:
//   clk          in   1                   clock, rising edge
//   rst          in   1                   synchronous active-high reset
//   digit_valid  in   1                   digit strobe
//   digit        in   DIGIT_W             digit value
//   clear        in   1                   abort current entry
//   lock_cmd     in   1                   relock request
//   prog_req     in   1                   start reprogramming (UNLOCKED only)
//   unlocked     out  1                   high in UNLOCKED/PROGRAM
//   locked_out   out  1                   high in LOCKOUT
//   bad_code     out  1                   pulse after a wrong code
//   code_saved   out  1                   pulse after a new code is committed
//   fail_cnt     out  $clog2(MAX_FAIL+1)  consecutive failures
//   digit_idx    out  $clog2(CODE_LEN+1)  digits entered so far

module locker_code_checker
  import locker_pkg::*;
#(
  parameter int unsigned                 DIGIT_W     = DEF_DIGIT_W,
  parameter int unsigned                 CODE_LEN    = DEF_CODE_LEN,
  parameter int unsigned                 MAX_FAIL    = 3,
  parameter int unsigned                 LOCKOUT_CYC = 16,
  parameter logic [DIGIT_W*CODE_LEN-1:0] RESET_CODE  = 16'h1234,
  parameter int unsigned                 RELOCK_CYC  = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            digit_valid,
  input  logic [DIGIT_W-1:0]              digit,
  input  logic                            clear,
  input  logic                            lock_cmd,
  input  logic                            prog_req,
  output logic                            unlocked,
  output logic                            locked_out,
  output logic                            bad_code,
  output logic                            code_saved,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
  output logic [$clog2(CODE_LEN+1)-1:0]   digit_idx
);

  localparam int unsigned CODE_W  = DIGIT_W * CODE_LEN;
  localparam int unsigned FW      = $clog2(MAX_FAIL + 1);
  localparam int unsigned IW      = $clog2(CODE_LEN + 1);
  // Both timer instances share one width so either build sizes them alike.
  localparam int unsigned TMAX    = (LOCKOUT_CYC > RELOCK_CYC) ? LOCKOUT_CYC : RELOCK_CYC;
  localparam int unsigned TIMER_W = $clog2(TMAX + 1);

  locker_state_t     state_q, state_d;
  logic [CODE_W-1:0] stored_q, stored_d;
  logic [CODE_W-1:0] shadow_q, shadow_d;
  logic              mm_q, mm_d;
  logic [FW-1:0]     fail_d;
  logic [IW-1:0]     idx_d;
  logic              bad_d, saved_d;
  logic              lockout_load, lockout_zero;

  locker_down_timer #(.W(TIMER_W)) u_lockout_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (lockout_load),
    .load_val (TIMER_W'(LOCKOUT_CYC - 1)),
    .en       (state_q == LOCKOUT),
    .zero     (lockout_zero)
  );

`ifdef LOCKER_AUTO_RELOCK_EN
  logic relock_load, relock_zero;

  // Reload on entry to UNLOCKED and on any activity there; frozen elsewhere.
  assign relock_load = ((state_q == LOCKED) && (state_d == UNLOCKED)) ||
                       ((state_q == UNLOCKED) && (digit_valid || prog_req));

  locker_down_timer #(.W(TIMER_W)) u_relock_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (relock_load),
    .load_val (TIMER_W'(RELOCK_CYC - 1)),
    .en       (state_q == UNLOCKED),
    .zero     (relock_zero)
  );
`endif

  always_comb begin
    logic [DIGIT_W-1:0] exp_digit;
    logic               last_digit;
    logic               mm_any;
    int unsigned        pos;

    state_d      = state_q;
    stored_d     = stored_q;
    shadow_d     = shadow_q;
    mm_d         = mm_q;
    fail_d       = fail_cnt;
    idx_d        = digit_idx;
    bad_d        = 1'b0;
    saved_d      = 1'b0;
    lockout_load = 1'b0;

    exp_digit  = DIGIT_W'(digit_at(MAX_CODE_W'(stored_q), 32'(digit_idx), DIGIT_W, CODE_LEN));
    last_digit = (32'(digit_idx) == CODE_LEN - 1);
    mm_any     = mm_q | (digit != exp_digit);
    pos        = (CODE_LEN - 1 - 32'(digit_idx)) * DIGIT_W;

    // Each cycle is owned by the highest-priority asserted command; if that
    // command means nothing in the current state the cycle does nothing, so
    // e.g. a digit arriving alongside prog_req while LOCKED is discarded.
    case (state_q)
      LOCKED: begin
        if (clear || lock_cmd) begin
          idx_d = '0;
          mm_d  = 1'b0;
        end else if (!prog_req && digit_valid) begin
          if (last_digit) begin
            idx_d = '0;
            mm_d  = 1'b0;
            if (!mm_any) begin
              state_d = UNLOCKED;
              fail_d  = '0;
            end else begin
              bad_d  = 1'b1;
              fail_d = fail_cnt + 1'b1;
              if (32'(fail_cnt) + 32'd1 >= MAX_FAIL) begin
                state_d      = LOCKOUT;
                lockout_load = 1'b1;
              end
            end
          end else begin
            idx_d = digit_idx + 1'b1;
            mm_d  = mm_any;
          end
        end
      end

      LOCKOUT: begin
        if (lockout_zero) begin
          state_d = LOCKED;
          fail_d  = '0;
          idx_d   = '0;
          mm_d    = 1'b0;
        end
      end

      UNLOCKED: begin
        if (!clear) begin
          if (lock_cmd) begin
            state_d = LOCKED;
          end else if (prog_req) begin
            state_d = PROGRAM;
            idx_d   = '0;
          end
        end
`ifdef LOCKER_AUTO_RELOCK_EN
        if ((state_d == UNLOCKED) && !digit_valid && !prog_req && relock_zero) begin
          state_d = LOCKED;
        end
`endif
      end

      PROGRAM: begin
        if (clear) begin
          state_d = UNLOCKED;
          idx_d   = '0;
        end else if (lock_cmd) begin
          state_d = LOCKED;
          idx_d   = '0;
        end else if (!prog_req && digit_valid) begin
          shadow_d = (shadow_q & ~(CODE_W'({DIGIT_W{1'b1}}) << pos)) |
                     (CODE_W'(digit) << pos);
          if (last_digit) begin
            stored_d = shadow_d;
            saved_d  = 1'b1;
            state_d  = UNLOCKED;
            idx_d    = '0;
          end else begin
            idx_d = digit_idx + 1'b1;
          end
        end
      end

      default: state_d = LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOCKED;
      stored_q   <= RESET_CODE;
      shadow_q   <= '0;
      mm_q       <= 1'b0;
      fail_cnt   <= '0;
      digit_idx  <= '0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      bad_code   <= 1'b0;
      code_saved <= 1'b0;
    end else begin
      state_q    <= state_d;
      stored_q   <= stored_d;
      shadow_q   <= shadow_d;
      mm_q       <= mm_d;
      fail_cnt   <= fail_d;
      digit_idx  <= idx_d;
      unlocked   <= (state_d == UNLOCKED) || (state_d == PROGRAM);
      locked_out <= (state_d == LOCKOUT);
      bad_code   <= bad_d;
      code_saved <= saved_d;
    end
  end

endmodule

// File: tb/tb_locker_code_checker.sv
// tb/tb_locker_code_checker.sv - directed and randomized bench for locker_code_checker

module tb_locker_code_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       clear = 1'b0;
  logic       lock_cmd = 1'b0;
  logic       prog_req = 1'b0;
  logic       unlocked, locked_out, bad_code, code_saved;
  logic [1:0] fail_cnt;
  logic [2:0] digit_idx;

  locker_code_checker dut (
    .clk         (clk),
    .rst         (rst),
    .digit_valid (digit_valid),
    .digit       (digit),
    .clear       (clear),
    .lock_cmd    (lock_cmd),
    .prog_req    (prog_req),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .bad_code    (bad_code),
    .code_saved  (code_saved),
    .fail_cnt    (fail_cnt),
    .digit_idx   (digit_idx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Reference model: code as a digit list, the entry in progress as a queue,
  // lockout as a countdown of remaining locked-out cycles.
  localparam int M_LOCKED = 0;
  localparam int M_OPEN   = 1;
  localparam int M_PROG   = 2;
  localparam int M_JAIL   = 3;

  int m_mode;
  int m_code[4];
  int m_entry[$];
  int m_new[$];
  int m_fails;
  int m_jail_left;
  bit m_bad, m_saved;

  task automatic model_reset();
    m_mode = M_LOCKED;
    m_code = '{1, 2, 3, 4};
    m_entry.delete();
    m_new.delete();
    m_fails = 0;
    m_jail_left = 0;
    m_bad = 0;
    m_saved = 0;
  endtask

  task automatic model_step(input bit dv, input int d, input bit c, input bit l, input bit p);
    bit ok;
    m_bad = 0;
    m_saved = 0;
    case (m_mode)
      M_JAIL: begin
        m_jail_left--;
        if (m_jail_left == 0) begin
          m_mode = M_LOCKED;
          m_fails = 0;
        end
      end
      M_LOCKED: begin
        if (c || l) m_entry.delete();
        else if (!p && dv) begin
          m_entry.push_back(d);
          if (m_entry.size() == 4) begin
            ok = 1;
            for (int k = 0; k < 4; k++) if (m_entry[k] != m_code[k]) ok = 0;
            m_entry.delete();
            if (ok) begin
              m_mode = M_OPEN;
              m_fails = 0;
            end else begin
              m_bad = 1;
              m_fails++;
              if (m_fails == 3) begin
                m_mode = M_JAIL;
                m_jail_left = 16;
              end
            end
          end
        end
      end
      M_OPEN: begin
        if (!c) begin
          if (l) m_mode = M_LOCKED;
          else if (p) begin
            m_mode = M_PROG;
            m_new.delete();
          end
        end
      end
      default: begin
        if (c) begin
          m_mode = M_OPEN;
          m_new.delete();
        end else if (l) begin
          m_mode = M_LOCKED;
          m_new.delete();
        end else if (!p && dv) begin
          m_new.push_back(d);
          if (m_new.size() == 4) begin
            for (int k = 0; k < 4; k++) m_code[k] = m_new[k];
            m_new.delete();
            m_saved = 1;
            m_mode = M_OPEN;
          end
        end
      end
    endcase
  endtask

  task automatic check_all();
    int exp_idx;
    exp_idx = (m_mode == M_LOCKED) ? m_entry.size() : (m_mode == M_PROG) ? m_new.size() : 0;
    check("unlocked",   32'(unlocked),   32'(m_mode == M_OPEN || m_mode == M_PROG));
    check("locked_out", 32'(locked_out), 32'(m_mode == M_JAIL));
    check("bad_code",   32'(bad_code),   32'(m_bad));
    check("code_saved", 32'(code_saved), 32'(m_saved));
    check("fail_cnt",   32'(fail_cnt),   32'(m_fails));
    check("digit_idx",  32'(digit_idx),  32'(exp_idx));
  endtask

  task automatic cycle(input bit r, input bit dv, input logic [3:0] d,
                       input bit c, input bit l, input bit p);
    @(negedge clk);
    rst = r;
    digit_valid = dv;
    digit = d;
    clear = c;
    lock_cmd = l;
    prog_req = p;
    @(posedge clk);
    cyc++;
    if (r) model_reset();
    else model_step(dv, int'(d), c, l, p);
    #1;
    check_all();
  endtask

  task automatic code4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    cycle(0, 1, a, 0, 0, 0);
    cycle(0, 1, b, 0, 0, 0);
    cycle(0, 1, c, 0, 0, 0);
    cycle(0, 1, d, 0, 0, 0);
  endtask

  task automatic idle();
    cycle(0, 0, 4'd0, 0, 0, 0);
  endtask

  int         lo_cnt;
  bit         r_r, r_dv, r_c, r_l, r_p;
  logic [3:0] r_d;

  initial begin
    model_reset();

    cycle(1, 0, 4'd0, 0, 0, 0);
    cycle(1, 0, 4'd0, 0, 0, 0);
    check("rst_unlocked", 32'(unlocked), 0);
    check("rst_fail_cnt", 32'(fail_cnt), 0);
    check("rst_digit_idx", 32'(digit_idx), 0);

    // correct code
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    check("good_unlocked", 32'(unlocked), 1);
    check("good_fail_cnt", 32'(fail_cnt), 0);
    cycle(0, 0, 4'd0, 0, 1, 0);
    check("relock", 32'(unlocked), 0);

    // wrong code
    code4(4'd1, 4'd2, 4'd3, 4'd5);
    check("wrong_bad_code", 32'(bad_code), 1);
    check("wrong_fail_cnt", 32'(fail_cnt), 1);
    check("wrong_unlocked", 32'(unlocked), 0);
    check("wrong_digit_idx", 32'(digit_idx), 0);
    idle();
    check("bad_code_one_cycle", 32'(bad_code), 0);

    // lockout after three failures; digits in the window are ignored
    code4(4'd1, 4'd2, 4'd3, 4'd5);
    code4(4'd9, 4'd9, 4'd9, 4'd9);
    lo_cnt = int'(locked_out);
    for (int k = 0; k < 16; k++) begin
      cycle(0, 1, 4'(k % 4 + 1), 0, 0, 0);
      lo_cnt += int'(locked_out);
    end
    check("lockout_len", 32'(lo_cnt), 16);
    check("after_lockout_fail_cnt", 32'(fail_cnt), 0);
    check("after_lockout_idx", 32'(digit_idx), 0);
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    check("post_lockout_unlock", 32'(unlocked), 1);

    // reprogram to 9876
    cycle(0, 0, 4'd0, 0, 0, 1);
    code4(4'd9, 4'd8, 4'd7, 4'd6);
    check("prog_code_saved", 32'(code_saved), 1);
    check("prog_unlocked", 32'(unlocked), 1);
    cycle(0, 0, 4'd0, 0, 1, 0);
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    check("old_code_bad", 32'(bad_code), 1);

    // abort: clear with a same-cycle digit
    cycle(0, 1, 4'd9, 0, 0, 0);
    cycle(0, 1, 4'd8, 0, 0, 0);
    cycle(0, 1, 4'd7, 1, 0, 0);
    check("clear_idx", 32'(digit_idx), 0);
    check("clear_fail_kept", 32'(fail_cnt), 1);
    code4(4'd9, 4'd8, 4'd7, 4'd6);
    check("new_code_unlock", 32'(unlocked), 1);

    // lock_cmd beats prog_req
    cycle(0, 0, 4'd0, 0, 1, 1);
    check("lock_beats_prog", 32'(unlocked), 0);

    // reset mid-PROGRAM restores the reset code
    code4(4'd9, 4'd8, 4'd7, 4'd6);
    cycle(0, 0, 4'd0, 0, 0, 1);
    cycle(0, 1, 4'd5, 0, 0, 0);
    cycle(0, 1, 4'd5, 0, 0, 0);
    cycle(1, 0, 4'd0, 0, 0, 0);
    code4(4'd1, 4'd2, 4'd3, 4'd4);
    check("reset_code_restored", 32'(unlocked), 1);

    // randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      r_r  = ($urandom_range(0, 299) == 0);
      r_dv = ($urandom_range(0, 9) < 6);
      r_c  = ($urandom_range(0, 99) < 3);
      r_l  = ($urandom_range(0, 99) < 4);
      r_p  = ($urandom_range(0, 99) < 5);
      if (m_mode == M_LOCKED && $urandom_range(0, 9) < 7)
        r_d = 4'(m_code[m_entry.size()]);
      else
        r_d = 4'($urandom_range(0, 15));
      cycle(r_r, r_dv, r_d, r_c, r_l, r_p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
